// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage between the program counter and the instruction ROM. It drives
//   the ROM address and chip select, captures the returned word into the
//   instruction register, and hands that word to decode over a valid/ready
//   handshake. It also handles jumps (PC load with flush), run/stop control and
//   sticky detection of the PC wrapping from the top address back to 0.
//
// Ports
//   clk          in   system clock, all state updates on the rising edge
//   reset        in   asynchronous, active-high reset
//   run          in   1 = fetch continuously, 0 = park after the current fetch
//   rom_address  out  ROM word address (always equal to pc)
//   rom_cs       out  ROM chip select, high only in REQ and CAPTURE
//   rom_data     in   ROM read data (high-Z while rom_cs is low)
//   ir           out  instruction register
//   ir_pc        out  address the ir word was fetched from
//   ir_valid     out  ir holds an instruction decode has not yet taken
//   ir_ready     in   decode accepts ir this cycle
//   jump         in   load pc from jump_target this cycle
//   jump_target  in   jump destination
//   pc           out  next address to fetch
//   wrapped      out  sticky flag: pc incremented from the top address to 0
// ----------------------------------------------------------------------------
module instruction_fetch #(
   parameter int                    ADDR_WIDTH = 5,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic                  rom_cs,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] ir,
   output logic [ADDR_WIDTH-1:0] ir_pc,
   output logic                  ir_valid,
   input  logic                  ir_ready,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  wrapped
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t state, state_next;

   // A jump during CAPTURE aborts the fetch, so the word is only taken when
   // no jump arrives on the same edge.
   logic capture;
   // Held word leaves the register either by handshake or by a jump flush.
   logic release_ir;

   assign capture     = (state == CAPTURE) && !jump;
   assign release_ir  = (state == HOLD) && (jump || ir_ready);
   assign rom_address = pc;
   // Decoded from registered state only, so an async reset drops it at once.
   assign rom_cs      = (state == REQ) || (state == CAPTURE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (run) state_next = REQ;
         REQ:     state_next = jump ? REQ : CAPTURE;
         CAPTURE: state_next = jump ? REQ : HOLD;
         HOLD: begin
            if (jump)          state_next = REQ;
            else if (ir_ready) state_next = run ? REQ : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= RESET_PC;
         ir       <= '0;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
         wrapped  <= 1'b0;
      end else begin
         // Jump wins over the post-capture increment; jumping to 0 is not a wrap.
         if (jump) begin
            pc <= jump_target;
         end else if (capture) begin
            pc <= pc + ADDR_WIDTH'(1);
            if (pc == '1) wrapped <= 1'b1;
         end

         if (capture) begin
            ir       <= rom_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
         end else if (release_ir) begin
            ir_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. A behavioural ROM holds
//   0xA0000000 + i at word i and drives the data bus only while rom_cs is high.
//   Inputs change 1ns after a rising edge; outputs are checked there too.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          run;
   logic [AW-1:0] rom_address;
   logic          rom_cs;
   wire  [DW-1:0] rom_data;
   logic [DW-1:0] ir;
   logic [AW-1:0] ir_pc;
   logic          ir_valid;
   logic          ir_ready;
   logic          jump;
   logic [AW-1:0] jump_target;
   logic [AW-1:0] pc;
   logic          wrapped;

   logic [DW-1:0] rom_mem [32];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign rom_data = rom_cs ? rom_mem[rom_address] : 'z;

   instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (
      .clk(clk), .reset(reset), .run(run),
      .rom_address(rom_address), .rom_cs(rom_cs), .rom_data(rom_data),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .jump(jump), .jump_target(jump_target), .pc(pc), .wrapped(wrapped)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold reset over an edge, then release 1ns after it with the given controls.
   task automatic do_reset(input logic r, input logic rdy);
      reset = 1'b1; run = r; ir_ready = rdy; jump = 1'b0; jump_target = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b1; ir_ready = 1'b1; jump = 1'b0; jump_target = '0;
      step(); step();
      checks++; if (pc !== 5'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
      checks++; if (rom_cs !== 1'b0) begin failures++; $display("FAIL reset_rom_cs got=%b exp=0", rom_cs); end
      checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
      checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", ir); end
      checks++; if (wrapped !== 1'b0) begin failures++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
      reset = 1'b0;
      step();
      checks++; if (rom_cs !== 1'b1) begin failures++; $display("FAIL release_rom_cs got=%b exp=1", rom_cs); end
      checks++; if (rom_address !== 5'd0) begin failures++; $display("FAIL release_addr got=%h exp=0", rom_address); end
   endtask

   // Continuous fetch with decode always ready: REQ, CAPTURE, HOLD repeating.
   task automatic test_stream();
      do_reset(1'b1, 1'b1);
      step();  // REQ
      for (int k = 0; k < 3; k++) begin
         step();  // CAPTURE
         checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL stream_cap_valid k=%0d got=%b exp=0", k, ir_valid); end
         step();  // HOLD
         checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL stream_hold_valid k=%0d got=%b exp=1", k, ir_valid); end
         checks++; if (ir !== 32'hA000_0000 + k) begin failures++; $display("FAIL stream_ir k=%0d got=%h exp=%h", k, ir, 32'hA000_0000 + k); end
         checks++; if (ir_pc !== AW'(k)) begin failures++; $display("FAIL stream_ir_pc k=%0d got=%h exp=%h", k, ir_pc, k); end
         checks++; if (pc !== AW'(k + 1)) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, pc, k + 1); end
         step();  // back to REQ after handshake
         checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL stream_req_valid k=%0d got=%b exp=0", k, ir_valid); end
         checks++; if (rom_cs !== 1'b1) begin failures++; $display("FAIL stream_req_cs k=%0d got=%b exp=1", k, rom_cs); end
      end
   endtask

   // Decode stalls: the word must stay put; then run drops and the FSM parks.
   task automatic test_stall();
      do_reset(1'b1, 1'b0);
      step(); step(); step();  // REQ, CAPTURE, HOLD
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (ir !== 32'hA000_0000 || ir_valid !== 1'b1 || rom_cs !== 1'b0 || pc !== 5'd1) begin
            failures++;
            $display("FAIL stall c=%0d got ir=%h v=%b cs=%b pc=%h exp ir=a0000000 v=1 cs=0 pc=01", c, ir, ir_valid, rom_cs, pc);
         end
      end
      run = 1'b0; ir_ready = 1'b1;
      step();
      checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL stop_valid got=%b exp=0", ir_valid); end
      step(); step();
      checks++; if (rom_cs !== 1'b0) begin failures++; $display("FAIL stop_parked_cs got=%b exp=0", rom_cs); end
      checks++; if (pc !== 5'd1) begin failures++; $display("FAIL stop_parked_pc got=%h exp=01", pc); end
   endtask

   // Jump while holding an unaccepted word: that word is flushed.
   task automatic test_jump_flush();
      do_reset(1'b1, 1'b0);
      step(); step(); step();  // HOLD with word 0
      jump = 1'b1; jump_target = 5'h1C;
      step();
      jump = 1'b0;
      checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", ir_valid); end
      checks++; if (pc !== 5'h1C) begin failures++; $display("FAIL flush_pc got=%h exp=1c", pc); end
      checks++; if (rom_cs !== 1'b1) begin failures++; $display("FAIL flush_cs got=%b exp=1", rom_cs); end
      step(); step();  // CAPTURE, HOLD
      checks++; if (ir !== 32'hA000_001C) begin failures++; $display("FAIL flush_ir got=%h exp=a000001c", ir); end
      checks++; if (ir_pc !== 5'h1C) begin failures++; $display("FAIL flush_ir_pc got=%h exp=1c", ir_pc); end
      checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL flush_new_valid got=%b exp=1", ir_valid); end
      checks++; if (pc !== 5'h1D) begin failures++; $display("FAIL flush_new_pc got=%h exp=1d", pc); end
   endtask

   // Jump to the top address; the increment after capture wraps pc.
   task automatic test_wrap();
      do_reset(1'b1, 1'b1);
      step();  // REQ
      jump = 1'b1; jump_target = 5'd31;
      step();  // REQ again, pc=31
      jump = 1'b0;
      checks++; if (wrapped !== 1'b0) begin failures++; $display("FAIL wrap_pre got=%b exp=0", wrapped); end
      step(); step();  // CAPTURE, HOLD
      checks++; if (ir_pc !== 5'd31) begin failures++; $display("FAIL wrap_ir_pc got=%h exp=1f", ir_pc); end
      checks++; if (ir !== 32'hA000_001F) begin failures++; $display("FAIL wrap_ir got=%h exp=a000001f", ir); end
      checks++; if (pc !== 5'd0) begin failures++; $display("FAIL wrap_pc got=%h exp=00", pc); end
      checks++; if (wrapped !== 1'b1) begin failures++; $display("FAIL wrap_set got=%b exp=1", wrapped); end
      step(); step(); step();  // REQ, CAPTURE, HOLD
      checks++; if (ir_pc !== 5'd0) begin failures++; $display("FAIL wrap_next_ir_pc got=%h exp=00", ir_pc); end
      checks++; if (ir !== 32'hA000_0000) begin failures++; $display("FAIL wrap_next_ir got=%h exp=a0000000", ir); end
      checks++; if (wrapped !== 1'b1) begin failures++; $display("FAIL wrap_sticky got=%b exp=1", wrapped); end
   endtask

   // Reset asserted between edges while in CAPTURE.
   task automatic test_async_reset();
      do_reset(1'b1, 1'b1);
      step(); step(); step();  // HOLD with word 0
      step(); step();          // REQ, CAPTURE of word 1
      checks++; if (rom_cs !== 1'b1) begin failures++; $display("FAIL areset_pre_cs got=%b exp=1", rom_cs); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (rom_cs !== 1'b0 || ir_valid !== 1'b0 || pc !== 5'd0 || ir !== 32'h0 || ir_pc !== 5'd0) begin
         failures++;
         $display("FAIL areset_immediate got cs=%b v=%b pc=%h ir=%h ir_pc=%h exp all zero", rom_cs, ir_valid, pc, ir, ir_pc);
      end
      step();
      checks++; if (ir !== 32'h0) begin failures++; $display("FAIL areset_no_load got=%h exp=0", ir); end
      reset = 1'b0;
      step();
      checks++; if (rom_cs !== 1'b1 || rom_address !== 5'd0) begin failures++; $display("FAIL areset_restart got cs=%b addr=%h exp cs=1 addr=00", rom_cs, rom_address); end
      step(); step();
      checks++; if (ir !== 32'hA000_0000 || ir_pc !== 5'd0) begin failures++; $display("FAIL areset_refetch got ir=%h ir_pc=%h exp ir=a0000000 ir_pc=00", ir, ir_pc); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom_mem[i] = 32'hA000_0000 + i;
      test_reset();
      test_stream();
      test_stall();
      test_jump_flush();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
